ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline; sits between ID and MEM.
- Registers the ID-to-EX bus under the shared stall protocol.
- Computes ALU results and the data SRAM request (address, byte enables, write data).
- Runs a 32-step iterative divider that holds the pipeline through a stall request.
- Drives the EX-to-MEM bus and the EX forwarding bus back to ID.

Parameters:
- ID_TO_EX_WD, 146, width of id_to_ex_bus.
- EX_TO_MEM_WD, 76, width of ex_to_mem_bus.
- EX_TO_ID_WD, 39, width of ex_to_id_bus.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  6 (StallBus)  stall vector; bit 2 = EX, bit 3 = MEM.
- id_to_ex_bus  in  146  {pc[145:114], alu_op[113:110], div_op[109:108], mem_en[107], mem_we[106], mem_size[105:104], sel_rf_res[103], rf_we[102], rf_waddr[101:97], sel_imm[96], rs_data[95:64], rt_data[63:32], imm[31:0]}.
- ex_to_mem_bus  out  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- ex_to_id_bus  out  39  {is_load[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- data_sram_en  out  1  SRAM access enable.
- data_sram_wen  out  4  SRAM byte write enables.
- data_sram_addr  out  32  SRAM byte address.
- data_sram_wdata  out  32  SRAM write data.
- stallreq_for_ex  out  1  EX stall request to the stall controller.

Behaviour:
- Input register:
  - rst → 0 (asynchronous).
  - stall[2]=Stop and stall[3]=NoStop → load 0 (bubble).
  - stall[2]=NoStop → load id_to_ex_bus.
  - Otherwise hold.
- Operand B = sel_imm ? imm : rt_data.
- alu_op (ex_result): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI (B<<16), 12 PASS (A).
  - Shifts use rs_data[4:0] as amount and shift B.
  - Codes 13–15 produce 0.
  - All arithmetic wraps modulo 2^32; no overflow trap.
- Memory request:
  - Address = rs_data + imm.
  - mem_size: 00 byte, 01 half, 11 word; 10 is treated as word.
  - Byte mask:
    - byte: 1 << addr[1:0].
    - half: 0011 when addr[1]=0, 1100 when addr[1]=1.
    - word: 1111.
  - Write data: byte replicated ×4; half replicated ×2; word as is.
  - data_sram_en = mem_en & aligned. data_sram_wen = mask when mem_en & mem_we & aligned, else 0.
  - Misaligned access (half with addr[0]=1; word with addr[1:0]≠0): en=0, wen=0, data_ram_en=0 on the bus, no trap.
- Bus fields:
  - data_ram_en on the bus = data_sram_en.
  - data_ram_wen on the bus carries the byte mask for both loads and stores.
  - When mem_en=1, ex_result = address.
- is_load = mem_en & ~mem_we.
- Divider, div_op: 00 none, 01 unsigned quotient, 10 signed quotient, 11 signed remainder.
- Divider FSM (IDLE/BUSY/DONE; counter 6 bits):
  - IDLE, div_op≠0, divisor≠0 → BUSY; counter=0; magnitudes latched; stallreq=1.
  - BUSY: one restoring step per cycle; stallreq=1. Leaves for DONE after step 32 (counter=31→DONE).
  - DONE: stallreq=0; result held in a 32-bit register.
  - DONE → IDLE on the first cycle with stall[2]=NoStop. DONE holds while EX is stalled by a downstream stage.
  - Total stall: 33 cycles from the instruction entering EX to stallreq falling.
  - When div_op≠0, ex_result = the divider result register, valid only in DONE.
- Divider arithmetic:
  - Signed quotient is negative iff the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - 0x80000000 / -1 → quotient 0x80000000, remainder 0.
- Divisor = 0: no stall (stallreq=0). Quotient = 0xFFFFFFFF; remainder = dividend.
- Reset mid-divide: FSM → IDLE, counter and partial results → 0, stallreq → 0.
- Reset values: all outputs 0. Outputs are combinational from the register and FSM, so they are 0 while rst is high.

Test Plan:
- ADD rs=0x7FFFFFFF, imm=1, sel_imm=1 → ex_result=0x80000000, rf_we passed through, no stall.
- Store byte, rs=0x1000, imm=3, rt=0xAB → addr=0x1003, wen=1000, wdata=0xABABABAB. Store half at 0x1001 → en=0, wen=0.
- Signed divide -7/2 with div_op=10 → stallreq high 33 cycles, ex_result=0xFFFFFFFD. With div_op=11 → 0xFFFFFFFF.
- Divide 5/0 with div_op=01 → no stall; ex_result=0xFFFFFFFF.
- stall[3]=Stop held 3 cycles while the divider is in DONE → result held and stable. Advances to IDLE after the stall releases.
- rst pulsed at BUSY cycle 10 → outputs 0 immediately. A following ADD executes with no residual stallreq.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if: groups the EX stage's pipeline buses, stall vector and data SRAM request.
//   stall           : 6-bit stall vector from the stall controller (bit 2 = EX, bit 3 = MEM)
//   id_to_ex_bus    : ID-to-EX instruction bus
//   ex_to_mem_bus   : EX-to-MEM bus
//   ex_to_id_bus    : EX forwarding bus back to ID
//   data_sram_*     : data SRAM request (enable, byte write enables, byte address, write data)
//   stallreq_for_ex : EX stall request (divider busy)
// modport master is the EX stage side; modport slave is the surrounding pipeline/SRAM side.
interface ex_stage_if #(
  parameter int unsigned ID_TO_EX_WD  = 146,
  parameter int unsigned EX_TO_MEM_WD = 76,
  parameter int unsigned EX_TO_ID_WD  = 39
);
  logic [5:0]              stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  logic                    stallreq_for_ex;

  modport master (
    input  stall,
    input  id_to_ex_bus,
    output ex_to_mem_bus,
    output ex_to_id_bus,
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    output stallreq_for_ex
  );

  modport slave (
    output stall,
    output id_to_ex_bus,
    input  ex_to_mem_bus,
    input  ex_to_id_bus,
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    input  stallreq_for_ex
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline, between ID and MEM.
//   clk    : clock, all state on posedge
//   rst    : asynchronous active-high reset
//   ex_io  : ex_stage_if.master -- stall vector and ID-to-EX bus in; EX-to-MEM bus,
//            EX-to-ID forwarding bus, data SRAM request and EX stall request out.
// Registers the ID-to-EX bus, computes the ALU result and the data SRAM request, and runs a
// 32-step restoring divider that holds the pipeline through stallreq_for_ex.
module ex_stage (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.master ex_io
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_st_e;

  // ---------------------------------------------------------------------------
  // Input register
  // ---------------------------------------------------------------------------
  logic [145:0] id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q <= '0;
    end else if (ex_io.stall[2] && !ex_io.stall[3]) begin
      id_q <= '0;
    end else if (!ex_io.stall[2]) begin
      id_q <= ex_io.id_to_ex_bus;
    end
  end

  logic [31:0] pc;
  logic [3:0]  alu_op;
  logic [1:0]  div_op;
  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        sel_imm;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm;

  assign pc         = id_q[145:114];
  assign alu_op     = id_q[113:110];
  assign div_op     = id_q[109:108];
  assign mem_en     = id_q[107];
  assign mem_we     = id_q[106];
  assign mem_size   = id_q[105:104];
  assign sel_rf_res = id_q[103];
  assign rf_we      = id_q[102];
  assign rf_waddr   = id_q[101:97];
  assign sel_imm    = id_q[96];
  assign rs_data    = id_q[95:64];
  assign rt_data    = id_q[63:32];
  assign imm        = id_q[31:0];

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;

  assign alu_a = rs_data;
  assign alu_b = sel_imm ? imm : rt_data;
  assign shamt = rs_data[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0:    alu_res = alu_a + alu_b;
      4'd1:    alu_res = alu_a - alu_b;
      4'd2:    alu_res = alu_a & alu_b;
      4'd3:    alu_res = alu_a | alu_b;
      4'd4:    alu_res = alu_a ^ alu_b;
      4'd5:    alu_res = ~(alu_a | alu_b);
      4'd6:    alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd7:    alu_res = {31'd0, alu_a < alu_b};
      4'd8:    alu_res = alu_b << shamt;
      4'd9:    alu_res = alu_b >> shamt;
      4'd10:   alu_res = $unsigned($signed(alu_b) >>> shamt);
      4'd11:   alu_res = {alu_b[15:0], 16'd0};
      4'd12:   alu_res = alu_a;
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data SRAM request
  // ---------------------------------------------------------------------------
  logic [31:0] mem_addr;
  logic        aligned;
  logic [3:0]  byte_mask;
  logic [31:0] wdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [3:0]  bus_wen;

  assign mem_addr = rs_data + imm;

  always_comb begin
    aligned   = 1'b1;
    byte_mask = 4'b1111;
    wdata     = rt_data;
    case (mem_size)
      2'b00: begin
        aligned   = 1'b1;
        byte_mask = 4'b0001 << mem_addr[1:0];
        wdata     = {4{rt_data[7:0]}};
      end
      2'b01: begin
        aligned   = ~mem_addr[0];
        byte_mask = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{rt_data[15:0]}};
      end
      // 2'b10 behaves as a word access
      default: begin
        aligned   = (mem_addr[1:0] == 2'b00);
        byte_mask = 4'b1111;
        wdata     = rt_data;
      end
    endcase
  end

  assign sram_en  = mem_en & aligned;
  assign sram_wen = (sram_en & mem_we) ? byte_mask : 4'b0000;
  // The bus carries the mask for loads too, so MEM can pick the right bytes.
  assign bus_wen  = sram_en ? byte_mask : 4'b0000;

  // ---------------------------------------------------------------------------
  // Iterative divider (restoring, one quotient bit per cycle)
  // ---------------------------------------------------------------------------
  div_st_e     st_q;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic [31:0] res_q;
  logic        q_neg_q;
  logic        r_neg_q;

  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_start;
  logic [32:0] rem_sh;
  logic        step_ge;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic [31:0] div_out;

  assign div_signed = div_op[1];
  assign a_neg      = div_signed & alu_a[31];
  assign b_neg      = div_signed & alu_b[31];
  assign a_mag      = a_neg ? (~alu_a + 32'd1) : alu_a;
  assign b_mag      = b_neg ? (~alu_b + 32'd1) : alu_b;
  // A zero divisor never starts the FSM; its result is produced combinationally below.
  assign div_start  = (div_op != 2'b00) && (alu_b != 32'd0);

  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    step_ge = (rem_sh >= {1'b0, dsr_q});
    // rem_sh - dsr_q is below dsr_q when taken, so 32-bit wrap-around is exact.
    rem_d   = step_ge ? (rem_sh[31:0] - dsr_q) : rem_sh[31:0];
    quo_d   = {quo_q[30:0], step_ge};
    q_fin   = q_neg_q ? (~quo_d + 32'd1) : quo_d;
    r_fin   = r_neg_q ? (~rem_d + 32'd1) : rem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      res_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      case (st_q)
        StIdle: begin
          if (div_start) begin
            st_q    <= StBusy;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= a_mag;
            dsr_q   <= b_mag;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
          end
        end
        StBusy: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            st_q  <= StDone;
            res_q <= (div_op == 2'b11) ? r_fin : q_fin;
          end
        end
        StDone: begin
          // Held while EX is stalled from downstream; the next instruction loads as we leave.
          if (!ex_io.stall[2]) begin
            st_q <= StIdle;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    div_out = '0;
    if (alu_b == 32'd0) begin
      div_out = (div_op == 2'b11) ? alu_a : 32'hFFFF_FFFF;
    end else if (st_q == StDone) begin
      div_out = res_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [31:0] ex_result;
  logic        is_load;

  always_comb begin
    ex_result = alu_res;
    if (mem_en) begin
      ex_result = mem_addr;
    end else if (div_op != 2'b00) begin
      ex_result = div_out;
    end
  end

  assign is_load = mem_en & ~mem_we;

  assign ex_io.ex_to_mem_bus   = {pc, sram_en, bus_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_io.ex_to_id_bus    = {is_load, rf_we, rf_waddr, ex_result};
  assign ex_io.data_sram_en    = sram_en;
  assign ex_io.data_sram_wen   = sram_wen;
  assign ex_io.data_sram_addr  = mem_addr;
  assign ex_io.data_sram_wdata = wdata;
  assign ex_io.stallreq_for_ex = ((st_q == StIdle) && div_start) || (st_q == StBusy);

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic [145:0] id_bus;
  logic [5:0]   force_stall;
  int           checks;
  int           errors;

  ex_stage_if u_if ();

  // Stall controller model: a divide holds PC..MEM; force_stall adds downstream stalls.
  assign u_if.stall        = force_stall | (u_if.stallreq_for_ex ? 6'b001111 : 6'b000000);
  assign u_if.id_to_ex_bus = id_bus;

  ex_stage u_dut (
    .clk   (clk),
    .rst   (rst),
    .ex_io (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0]  AluOp [13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                         4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
  localparam logic [31:0] AluRs [13] = '{32'h3, 32'hF0F0_1234, 32'hF000_0000, 32'hFFFF_0000,
                                         32'h00FF_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                         32'h0000_0024, 32'h4, 32'h4, 32'h7777_7777,
                                         32'hDEAD_BEEF, 32'h5};
  localparam logic [31:0] AluRt [13] = '{32'h5, 32'h0FF0_FF00, 32'h0000_000F, 32'h0F0F_0F0F,
                                         32'h0F00_0F00, 32'h1, 32'h1, 32'h0000_0011,
                                         32'h8000_0000, 32'h8000_0000, 32'h0000_1234,
                                         32'h1111_1111, 32'h6};
  localparam logic [31:0] AluExp [13] = '{32'hFFFF_FFFE, 32'h00F0_1200, 32'hF000_000F,
                                          32'hF0F0_0F0F, 32'hF000_F000, 32'h1, 32'h0,
                                          32'h0000_0110, 32'h0800_0000, 32'hF800_0000,
                                          32'h1234_0000, 32'hDEAD_BEEF, 32'h0};

  function automatic logic [145:0] mk(input logic [3:0] alu_op, input logic [1:0] div_op,
                                      input logic mem_en, input logic mem_we,
                                      input logic [1:0] mem_size, input logic sel_imm,
                                      input logic [31:0] rs, input logic [31:0] rt,
                                      input logic [31:0] imm);
    return {32'h0000_4000, alu_op, div_op, mem_en, mem_we, mem_size, mem_en & ~mem_we,
            1'b1, 5'd9, sel_imm, rs, rt, imm};
  endfunction

  // Present an instruction and sample just after the edge that moves it into EX.
  task automatic issue(input logic [145:0] v);
    @(negedge clk);
    id_bus = v;
    @(posedge clk);
    #1;
  endtask

  // Issue a divide and count the cycles stallreq_for_ex stays high (bounded).
  task automatic run_div(input logic [145:0] v, output int n);
    issue(v);
    id_bus = '0;
    n = 0;
    while (u_if.stallreq_for_ex === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    id_bus = mk(4'd0, 2'b00, 1'b1, 1'b1, 2'b11, 1'b1, 32'h100, 32'h55, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (u_if.ex_to_mem_bus !== 76'd0) begin
      errors++; $display("FAIL reset_mem_bus got %h want 0", u_if.ex_to_mem_bus);
    end
    checks++;
    if (u_if.ex_to_id_bus !== 39'd0) begin
      errors++; $display("FAIL reset_id_bus got %h want 0", u_if.ex_to_id_bus);
    end
    checks++;
    if ({u_if.data_sram_en, u_if.data_sram_wen} !== 5'd0) begin
      errors++; $display("FAIL reset_sram_en got %b%b want 0", u_if.data_sram_en,
                         u_if.data_sram_wen);
    end
    checks++;
    if ({u_if.data_sram_addr, u_if.data_sram_wdata} !== 64'd0) begin
      errors++; $display("FAIL reset_sram_addr got %h %h want 0", u_if.data_sram_addr,
                         u_if.data_sram_wdata);
    end
    checks++;
    if (u_if.stallreq_for_ex !== 1'b0) begin
      errors++; $display("FAIL reset_stallreq got %b want 0", u_if.stallreq_for_ex);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu;
    issue(mk(4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 32'h7FFF_FFFF, 32'h0BAD_0000, 32'h1));
    checks++;
    if (u_if.ex_to_id_bus !== {1'b0, 1'b1, 5'd9, 32'h8000_0000}) begin
      errors++; $display("FAIL add_imm got %h want %h", u_if.ex_to_id_bus,
                         {1'b0, 1'b1, 5'd9, 32'h8000_0000});
    end
    checks++;
    if (u_if.ex_to_mem_bus[75:32] !== {32'h0000_4000, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd9}) begin
      errors++; $display("FAIL add_fields got %h want %h", u_if.ex_to_mem_bus[75:32],
                         {32'h0000_4000, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd9});
    end
    checks++;
    if (u_if.stallreq_for_ex !== 1'b0) begin
      errors++; $display("FAIL add_stall got %b want 0", u_if.stallreq_for_ex);
    end
    for (int i = 0; i < 13; i++) begin
      issue(mk(AluOp[i], 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, AluRs[i], AluRt[i], 32'h0000_FFFF));
      checks++;
      if (u_if.ex_to_mem_bus[31:0] !== AluExp[i] || u_if.ex_to_id_bus[31:0] !== AluExp[i]) begin
        errors++; $display("FAIL alu_op%0d got %h want %h", AluOp[i], u_if.ex_to_mem_bus[31:0],
                           AluExp[i]);
      end
    end
  endtask

  task automatic test_mem;
    issue(mk(4'd0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 32'h1000, 32'hAB, 32'h3));
    checks++;
    if ({u_if.data_sram_en, u_if.data_sram_wen, u_if.data_sram_addr, u_if.data_sram_wdata}
        !== {1'b1, 4'b1000, 32'h1003, 32'hABAB_ABAB}) begin
      errors++; $display("FAIL sb_req got %b %b %h %h want 1 1000 1003 abababab",
                         u_if.data_sram_en, u_if.data_sram_wen, u_if.data_sram_addr,
                         u_if.data_sram_wdata);
    end
    checks++;
    if ({u_if.ex_to_mem_bus[43:39], u_if.ex_to_mem_bus[31:0], u_if.ex_to_id_bus[38]}
        !== {1'b1, 4'b1000, 32'h1003, 1'b0}) begin
      errors++; $display("FAIL sb_bus got %h want 1 8 1003 0", u_if.ex_to_mem_bus[43:0]);
    end
    issue(mk(4'd0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b1, 32'h1000, 32'h1234, 32'h1));
    checks++;
    if ({u_if.data_sram_en, u_if.data_sram_wen, u_if.ex_to_mem_bus[43]} !== 6'd0) begin
      errors++; $display("FAIL sh_misaligned got %b %b %b want 0 0000 0", u_if.data_sram_en,
                         u_if.data_sram_wen, u_if.ex_to_mem_bus[43]);
    end
    issue(mk(4'd0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b1, 32'h1000, 32'hCAFE_1234, 32'h2));
    checks++;
    if ({u_if.data_sram_en, u_if.data_sram_wen, u_if.data_sram_wdata}
        !== {1'b1, 4'b1100, 32'h1234_1234}) begin
      errors++; $display("FAIL sh_upper got %b %b %h want 1 1100 12341234", u_if.data_sram_en,
                         u_if.data_sram_wen, u_if.data_sram_wdata);
    end
    issue(mk(4'd0, 2'b00, 1'b1, 1'b0, 2'b11, 1'b1, 32'h2000, 32'h9999, 32'h4));
    checks++;
    if ({u_if.data_sram_en, u_if.data_sram_wen, u_if.ex_to_mem_bus[42:39],
         u_if.ex_to_id_bus[38], u_if.ex_to_id_bus[31:0]}
        !== {1'b1, 4'b0000, 4'b1111, 1'b1, 32'h2004}) begin
      errors++; $display("FAIL lw_req got %b %b %b %b %h want 1 0000 1111 1 2004",
                         u_if.data_sram_en, u_if.data_sram_wen, u_if.ex_to_mem_bus[42:39],
                         u_if.ex_to_id_bus[38], u_if.ex_to_id_bus[31:0]);
    end
    issue(mk(4'd0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 32'h2000, 32'h1122_3344, 32'h8));
    checks++;
    if ({u_if.data_sram_en, u_if.data_sram_wen, u_if.data_sram_wdata}
        !== {1'b1, 4'b1111, 32'h1122_3344}) begin
      errors++; $display("FAIL size10_word got %b %b %h want 1 1111 11223344",
                         u_if.data_sram_en, u_if.data_sram_wen, u_if.data_sram_wdata);
    end
    issue(mk(4'd0, 2'b00, 1'b1, 1'b0, 2'b11, 1'b1, 32'h2000, 32'h0, 32'h2));
    checks++;
    if ({u_if.data_sram_en, u_if.ex_to_mem_bus[43]} !== 2'b00) begin
      errors++; $display("FAIL lw_misaligned got %b %b want 0 0", u_if.data_sram_en,
                         u_if.ex_to_mem_bus[43]);
    end
  endtask

  task automatic div_case(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    int n;
    run_div(mk(4'd0, op, 1'b0, 1'b0, 2'b00, 1'b0, a, b, 32'h0), n);
    checks++;
    if (n != 33) begin
      errors++; $display("FAIL div_stall_len op%0d got %0d want 33", op, n);
    end
    checks++;
    if (u_if.ex_to_id_bus[31:0] !== exp) begin
      errors++; $display("FAIL div_result op%0d %h/%h got %h want %h", op, a, b,
                         u_if.ex_to_id_bus[31:0], exp);
    end
  endtask

  task automatic test_div;
    div_case(2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD);
    div_case(2'b11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF);
    div_case(2'b11, 32'h7, 32'hFFFF_FFFE, 32'h1);
    div_case(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    div_case(2'b01, 32'd100, 32'd7, 32'd14);
    @(posedge clk);
    #1;
    checks++;
    if (u_if.stallreq_for_ex !== 1'b0 || u_if.ex_to_id_bus[31:0] !== 32'd0) begin
      errors++; $display("FAIL div_release got %b %h want 0 0", u_if.stallreq_for_ex,
                         u_if.ex_to_id_bus[31:0]);
    end
  endtask

  task automatic test_div_zero;
    issue(mk(4'd0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 32'd5, 32'd0, 32'h0));
    checks++;
    if (u_if.stallreq_for_ex !== 1'b0 || u_if.ex_to_id_bus[31:0] !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL divz_quot got %b %h want 0 ffffffff", u_if.stallreq_for_ex,
                         u_if.ex_to_id_bus[31:0]);
    end
    issue(mk(4'd0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 32'd5, 32'd0, 32'h0));
    checks++;
    if (u_if.stallreq_for_ex !== 1'b0 || u_if.ex_to_id_bus[31:0] !== 32'd5) begin
      errors++; $display("FAIL divz_rem got %b %h want 0 5", u_if.stallreq_for_ex,
                         u_if.ex_to_id_bus[31:0]);
    end
  endtask

  task automatic test_mem_stall;
    div_case(2'b01, 32'd100, 32'd7, 32'd14);
    force_stall = 6'b001111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (u_if.ex_to_id_bus[31:0] !== 32'd14 || u_if.stallreq_for_ex !== 1'b0) begin
        errors++; $display("FAIL done_hold cyc%0d got %h %b want 0000000e 0", i,
                           u_if.ex_to_id_bus[31:0], u_if.stallreq_for_ex);
      end
    end
    force_stall = 6'b000000;
    // A fresh divide only stalls again if the FSM went back to idle.
    div_case(2'b01, 32'd9, 32'd3, 32'd3);
  endtask

  task automatic test_bubble;
    issue(mk(4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 32'd2, 32'd0, 32'd3));
    checks++;
    if (u_if.ex_to_id_bus !== {1'b0, 1'b1, 5'd9, 32'd5}) begin
      errors++; $display("FAIL bubble_pre got %h want %h", u_if.ex_to_id_bus,
                         {1'b0, 1'b1, 5'd9, 32'd5});
    end
    force_stall = 6'b000100;
    @(posedge clk);
    #1;
    force_stall = 6'b000000;
    checks++;
    if (u_if.ex_to_mem_bus !== 76'd0 || u_if.ex_to_id_bus !== 39'd0) begin
      errors++; $display("FAIL bubble got %h %h want 0 0", u_if.ex_to_mem_bus,
                         u_if.ex_to_id_bus);
    end
  endtask

  task automatic test_reset_mid_div;
    issue(mk(4'd0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 32'd100, 32'd7, 32'h0));
    id_bus = '0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (u_if.stallreq_for_ex !== 1'b1) begin
      errors++; $display("FAIL busy_stall got %b want 1", u_if.stallreq_for_ex);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (u_if.stallreq_for_ex !== 1'b0 || u_if.ex_to_mem_bus !== 76'd0 ||
        u_if.ex_to_id_bus !== 39'd0 || u_if.data_sram_en !== 1'b0) begin
      errors++; $display("FAIL rst_mid_div got %b %h %h want 0 0 0", u_if.stallreq_for_ex,
                         u_if.ex_to_mem_bus, u_if.ex_to_id_bus);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(mk(4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 32'd2, 32'd0, 32'd3));
    checks++;
    if (u_if.ex_to_id_bus[31:0] !== 32'd5 || u_if.stallreq_for_ex !== 1'b0) begin
      errors++; $display("FAIL post_rst_add got %h %b want 5 0", u_if.ex_to_id_bus[31:0],
                         u_if.stallreq_for_ex);
    end
    @(posedge clk);
    #1;
    checks++;
    if (u_if.stallreq_for_ex !== 1'b0) begin
      errors++; $display("FAIL post_rst_stall got %b want 0", u_if.stallreq_for_ex);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    id_bus      = '0;
    force_stall = 6'b000000;
    test_reset;
    test_alu;
    test_mem;
    test_div;
    test_div_zero;
    test_mem_stall;
    test_bubble;
    test_reset_mid_div;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
